// File: rtl/udp_receive.sv
// GMII UDP/IPv4 receiver: filters on MAC/IP/port, streams the payload to a FIFO, then pulses a verdict from the FCS check.
// States: IDLE hunt, PREAMBLE 55s, MAC/IPHDR/UDPHDR header bytes, DATA payload, TAIL pad+FCS, DROP discard to rxdv low.
module udp_receive #(
  parameter logic [47:0] LOCAL_MAC    = 48'h000A3501FEC0,
  parameter logic [31:0] LOCAL_IP     = 32'hC0A80002,
  parameter logic [15:0] LOCAL_PORT   = 16'h1F90,
  parameter bit          ACCEPT_BCAST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxdv,
  input  logic        rxer,
  input  logic [7:0]  datain,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [7:0]  fifo_data,
  output logic        frame_good,
  output logic        frame_bad,
  output logic [3:0]  rx_state,
  output logic [15:0] frame_index,
  output logic [15:0] rx_data_length,
  output logic [31:0] src_ip
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_PREAMBLE = 4'd1,
    S_MAC      = 4'd2,
    S_IPHDR    = 4'd3,
    S_UDPHDR   = 4'd4,
    S_DATA     = 4'd5,
    S_TAIL     = 4'd6,
    S_DROP     = 4'd7
  } state_t;

  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  state_t      r_state;
  logic        r_armed;
  logic [4:0]  r_cnt;
  logic [31:0] r_crc;
  logic        r_ucast_ok, r_bcast_ok, r_hdr_ok;
  logic [7:0]  r_hi;
  logic [15:0] r_csum;
  logic [15:0] r_ident, r_len, r_remain;
  logic [31:0] r_sip;
  logic [2:0]  r_tail_cnt;
  logic        r_tail_err;
  logic        r_wr_en, r_good, r_bad;
  logic [7:0]  r_fifo_data;
  logic [15:0] r_frame_index, r_rx_len;
  logic [31:0] r_src_ip;

  logic [31:0] w_crc_nxt;
  logic [16:0] w_csum_sum;
  logic [15:0] w_csum_fold;
  logic [7:0]  w_mac_byte, w_ip_byte;

  assign w_crc_nxt   = crc_next(r_crc, datain);
  assign w_csum_sum  = {1'b0, r_csum} + {1'b0, r_hi, datain};
  assign w_csum_fold = w_csum_sum[15:0] + {15'd0, w_csum_sum[16]};

  always_comb begin
    w_mac_byte = 8'h00;
    w_ip_byte  = 8'h00;
    case (r_cnt)
      5'd0:  w_mac_byte = LOCAL_MAC[47:40];
      5'd1:  w_mac_byte = LOCAL_MAC[39:32];
      5'd2:  w_mac_byte = LOCAL_MAC[31:24];
      5'd3:  w_mac_byte = LOCAL_MAC[23:16];
      5'd4:  w_mac_byte = LOCAL_MAC[15:8];
      5'd5:  w_mac_byte = LOCAL_MAC[7:0];
      5'd16: w_ip_byte  = LOCAL_IP[31:24];
      5'd17: w_ip_byte  = LOCAL_IP[23:16];
      5'd18: w_ip_byte  = LOCAL_IP[15:8];
      5'd19: w_ip_byte  = LOCAL_IP[7:0];
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_armed       <= 1'b0;
      r_cnt         <= 5'd0;
      r_crc         <= 32'hFFFFFFFF;
      r_ucast_ok    <= 1'b0;
      r_bcast_ok    <= 1'b0;
      r_hdr_ok      <= 1'b0;
      r_hi          <= 8'h00;
      r_csum        <= 16'h0000;
      r_ident       <= 16'h0000;
      r_len         <= 16'h0000;
      r_remain      <= 16'h0000;
      r_sip         <= 32'h0;
      r_tail_cnt    <= 3'd0;
      r_tail_err    <= 1'b0;
      r_wr_en       <= 1'b0;
      r_good        <= 1'b0;
      r_bad         <= 1'b0;
      r_fifo_data   <= 8'h00;
      r_frame_index <= 16'h0000;
      r_rx_len      <= 16'h0000;
      r_src_ip      <= 32'h0;
    end else begin
      r_wr_en <= 1'b0;
      r_good  <= 1'b0;
      r_bad   <= 1'b0;
      // Once reset, hold off until the line goes idle so a half-seen frame is never parsed.
      if (!rxdv) r_armed <= 1'b1;
      if (rxdv) r_crc <= w_crc_nxt;
      case (r_state)
        S_IDLE: begin
          if (rxdv && r_armed) r_state <= (datain == 8'h55) ? S_PREAMBLE : S_DROP;
        end
        S_PREAMBLE: begin
          if (!rxdv) r_state <= S_IDLE;
          else if (datain == 8'hD5) begin
            r_state    <= S_MAC;
            r_cnt      <= 5'd0;
            r_crc      <= 32'hFFFFFFFF;
            r_ucast_ok <= 1'b1;
            r_bcast_ok <= 1'b1;
            r_hdr_ok   <= 1'b1;
          end else if (datain != 8'h55) r_state <= S_DROP;
        end
        S_MAC: begin
          if (!rxdv) r_state <= S_IDLE;
          else if (rxer) r_state <= S_DROP;
          else begin
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt < 5'd6) begin
              if (datain != w_mac_byte) r_ucast_ok <= 1'b0;
              if (datain != 8'hFF) r_bcast_ok <= 1'b0;
            end
            if (r_cnt == 5'd12 && datain != 8'h08) r_hdr_ok <= 1'b0;
            if (r_cnt == 5'd13) begin
              if ((r_ucast_ok || (ACCEPT_BCAST && r_bcast_ok)) && r_hdr_ok && datain == 8'h00) begin
                r_state <= S_IPHDR;
                r_cnt   <= 5'd0;
                r_csum  <= 16'h0000;
              end else r_state <= S_DROP;
            end
          end
        end
        S_IPHDR: begin
          if (!rxdv) r_state <= S_IDLE;
          else if (rxer) r_state <= S_DROP;
          else begin
            r_cnt <= r_cnt + 5'd1;
            if (!r_cnt[0]) r_hi <= datain;
            else r_csum <= w_csum_fold;
            case (r_cnt)
              5'd0: if (datain != 8'h45) r_hdr_ok <= 1'b0;
              5'd4: r_ident[15:8] <= datain;
              5'd5: r_ident[7:0] <= datain;
              5'd9: if (datain != 8'h11) r_hdr_ok <= 1'b0;
              5'd12, 5'd13, 5'd14, 5'd15: r_sip <= {r_sip[23:0], datain};
              5'd16, 5'd17, 5'd18: if (datain != w_ip_byte) r_hdr_ok <= 1'b0;
              5'd19: begin
                if (r_hdr_ok && datain == w_ip_byte) begin
                  r_state <= S_UDPHDR;
                  r_cnt   <= 5'd0;
                end else r_state <= S_DROP;
              end
              default: ;
            endcase
          end
        end
        S_UDPHDR: begin
          if (!rxdv) r_state <= S_IDLE;
          else if (rxer) r_state <= S_DROP;
          else begin
            r_cnt <= r_cnt + 5'd1;
            case (r_cnt)
              5'd1: if (r_csum != 16'hFFFF) r_state <= S_DROP;
              5'd2: if (datain != LOCAL_PORT[15:8]) r_hdr_ok <= 1'b0;
              5'd3: if (datain != LOCAL_PORT[7:0]) r_hdr_ok <= 1'b0;
              5'd4: r_len[15:8] <= datain;
              5'd5: r_len[7:0] <= datain;
              5'd7: begin
                if (r_hdr_ok && r_len >= 16'd8) begin
                  r_frame_index <= r_ident;
                  r_rx_len      <= r_len;
                  r_src_ip      <= r_sip;
                  r_remain      <= r_len - 16'd8;
                  r_tail_cnt    <= 3'd0;
                  r_tail_err    <= 1'b0;
                  r_state       <= (r_len == 16'd8) ? S_TAIL : S_DATA;
                end else r_state <= S_DROP;
              end
              default: ;
            endcase
          end
        end
        S_DATA: begin
          if (!rxdv || rxer || fifo_full) begin
            r_state <= S_DROP;
            r_bad   <= 1'b1;
          end else begin
            r_wr_en     <= 1'b1;
            r_fifo_data <= datain;
            r_remain    <= r_remain - 16'd1;
            if (r_remain == 16'd1) r_state <= S_TAIL;
          end
        end
        S_TAIL: begin
          if (rxdv) begin
            if (r_tail_cnt != 3'd4) r_tail_cnt <= r_tail_cnt + 3'd1;
            if (rxer) r_tail_err <= 1'b1;
          end else begin
            if (r_tail_cnt == 3'd4 && r_crc == CRC_RESIDUE && !r_tail_err) r_good <= 1'b1;
            else r_bad <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_DROP: begin
          if (!rxdv) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign fifo_wr_en     = r_wr_en;
  assign fifo_data      = r_fifo_data;
  assign frame_good     = r_good;
  assign frame_bad      = r_bad;
  assign rx_state       = r_state;
  assign frame_index    = r_frame_index;
  assign rx_data_length = r_rx_len;
  assign src_ip         = r_src_ip;

endmodule
